// File: rtl/icache_direct_mapped.sv
// -----------------------------------------------------------------------------
// icache_direct_mapped
//
// Direct-mapped, read-only instruction cache between the fetch stage and
// instruction memory. LINES = 2**INDEX_W lines of WORDS = 2**WOFF_W words each.
// A hit returns the instruction combinationally in the same cycle. A miss
// stalls fetch and refills the whole line, one word per req/ack beat, in
// ascending word order. A flush invalidates every line. Saturating hit/miss
// counters are provided for performance monitoring.
//
// Address split: [ tag | index | word | 2'b00 ]
//
// Ports
//   clk        in   1       clock, all state updates on posedge
//   reset      in   1       asynchronous active-low reset
//   cpu_req    in   1       fetch request valid
//   cpu_addr   in   ADDR_W  fetch byte address, bits [1:0] ignored
//   cpu_instr  out  DATA_W  instruction, valid when cpu_ready=1 (else 0)
//   cpu_ready  out  1       hit this cycle
//   cpu_stall  out  1       fetch must hold PC
//   flush      in   1       invalidate all lines
//   mem_req    out  1       refill beat request, held until acked
//   mem_addr   out  ADDR_W  word-aligned beat address (0 when idle)
//   mem_ack    in   1       one-cycle pulse, mem_rdata valid
//   mem_rdata  in   DATA_W  refill data
//   hit_cnt    out  CNT_W   saturating count of hit cycles
//   miss_cnt   out  CNT_W   saturating count of misses
// -----------------------------------------------------------------------------
module icache_direct_mapped #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int INDEX_W = 2,
    parameter int WOFF_W  = 2,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic [ADDR_W-1:0] cpu_addr,
    output logic [DATA_W-1:0] cpu_instr,
    output logic              cpu_ready,
    output logic              cpu_stall,
    input  logic              flush,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [CNT_W-1:0]  hit_cnt,
    output logic [CNT_W-1:0]  miss_cnt
);

    localparam int TAG_W = ADDR_W - INDEX_W - WOFF_W - 2;
    localparam int LINES = 1 << INDEX_W;
    localparam int WORDS = 1 << WOFF_W;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic {
        S_IDLE,
        S_FILL
    } state_t;

    state_t r_state;
    state_t w_state_next;

    // Tag and data storage carry no reset; the valid bits alone gate their use.
    logic [TAG_W-1:0]  r_tag  [LINES];
    logic [DATA_W-1:0] r_data [LINES*WORDS];

    logic [TAG_W-1:0]   r_fill_tag;
    logic [INDEX_W-1:0] r_fill_idx;
    logic [WOFF_W-1:0]  r_beat;
    logic               r_flush_pend;
    logic [CNT_W-1:0]   r_hit_cnt;
    logic [CNT_W-1:0]   r_miss_cnt;

    logic [LINES-1:0]   w_valid;
    logic [TAG_W-1:0]   w_tag;
    logic [INDEX_W-1:0] w_idx;
    logic [WOFF_W-1:0]  w_word;
    logic               w_idle;
    logic               w_hit;
    logic               w_ready;
    logic               w_miss_start;
    logic               w_beat_done;
    logic               w_last_beat;
    logic               w_clear_all;
    logic               w_unused;

    // ------------------------------------------------------------------
    // Combinational lookup
    // ------------------------------------------------------------------
    assign w_tag    = cpu_addr[ADDR_W-1 -: TAG_W];
    assign w_idx    = cpu_addr[WOFF_W+2 +: INDEX_W];
    assign w_word   = cpu_addr[2 +: WOFF_W];
    assign w_unused = ^cpu_addr[1:0];

    assign w_idle       = (r_state == S_IDLE);
    assign w_hit        = w_valid[w_idx] && (r_tag[w_idx] == w_tag);
    assign w_ready      = cpu_req && w_idle && w_hit && !flush;
    // A flush cycle never starts a refill, even on a miss.
    assign w_miss_start = cpu_req && w_idle && !w_hit && !flush;
    // Acks are only meaningful while a refill is in flight.
    assign w_beat_done  = (r_state == S_FILL) && mem_ack;
    assign w_last_beat  = w_beat_done && (r_beat == WOFF_W'(WORDS - 1));
    // A flush seen at any point of a refill (including its final edge)
    // also wipes the line being filled.
    assign w_clear_all  = (w_idle && flush) ||
                          (w_last_beat && (r_flush_pend || flush));

    assign cpu_ready = w_ready;
    assign cpu_stall = cpu_req && !w_ready;
    assign cpu_instr = w_ready ? r_data[{w_idx, w_word}] : '0;
    assign hit_cnt   = r_hit_cnt;
    assign miss_cnt  = r_miss_cnt;

    // ------------------------------------------------------------------
    // FSM: next state and memory-side outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        mem_req      = 1'b0;
        mem_addr     = '0;
        case (r_state)
            S_IDLE: begin
                if (w_miss_start) begin
                    w_state_next = S_FILL;
                end
            end
            S_FILL: begin
                mem_req  = 1'b1;
                mem_addr = {r_fill_tag, r_fill_idx, r_beat, 2'b00};
                if (w_last_beat) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_fill_tag   <= '0;
            r_fill_idx   <= '0;
            r_beat       <= '0;
            r_flush_pend <= 1'b0;
            r_hit_cnt    <= '0;
            r_miss_cnt   <= '0;
        end else begin
            r_state <= w_state_next;

            if (w_miss_start) begin
                r_fill_tag <= w_tag;
                r_fill_idx <= w_idx;
                r_beat     <= '0;
                if (r_miss_cnt != CNT_MAX) begin
                    r_miss_cnt <= r_miss_cnt + CNT_W'(1);
                end
            end

            // Natural wrap returns the counter to 0 after the last word.
            if (w_beat_done) begin
                r_beat <= r_beat + WOFF_W'(1);
            end

            if (r_state == S_FILL) begin
                r_flush_pend <= (r_flush_pend || flush) && !w_last_beat;
            end

            if (w_ready && (r_hit_cnt != CNT_MAX)) begin
                r_hit_cnt <= r_hit_cnt + CNT_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Per-line valid bits
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < LINES; gi++) begin : g_valid
            logic r_v;
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    r_v <= 1'b0;
                end else if (w_clear_all) begin
                    r_v <= 1'b0;
                end else if (w_last_beat && (r_fill_idx == INDEX_W'(gi))) begin
                    r_v <= 1'b1;
                end
            end
            assign w_valid[gi] = r_v;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Tag/data arrays: written during refill, read asynchronously so a
    // hit is answered in the same cycle.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_beat_done) begin
            r_data[{r_fill_idx, r_beat}] <= mem_rdata;
        end
        if (w_last_beat) begin
            r_tag[r_fill_idx] <= r_fill_tag;
        end
    end

endmodule
